// File: rtl/sdr_move_gen_pkg.sv
// -----------------------------------------------------------------------------
// sdr_move_gen_pkg
// Shared definitions for the down-right checkers move generator.
//   BOARD_SQ   : squares on the board (32), index = 4*row + col, row 0 on top
//   ROW_SQ     : playable squares per row (4)
//   ROW_CNT    : rows on the board (8)
//   SDR_BORDER : destinations that no source square shifts into
//                (squares 0,1,2,3,8,16,24)
//   state_e    : FSM state encoding of the sequential engine
// -----------------------------------------------------------------------------
package sdr_move_gen_pkg;

   localparam int BOARD_SQ = 32;
   localparam int ROW_SQ   = 4;
   localparam int ROW_CNT  = 8;

   localparam logic [BOARD_SQ-1:0] SDR_BORDER = 32'h0101_010F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT1 = 2'd1,
      ST_SHIFT2 = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage : sdr_move_gen_pkg

// File: rtl/sdr_move_gen_sdr.sv
// -----------------------------------------------------------------------------
// sdr_move_gen_sdr
// Purely combinational down-right diagonal shifter for the 32-square board.
//   Even row r, col c        -> row r+1, col c    (index + 4)
//   Odd  row r, col c < 3    -> row r+1, col c+1  (index + 5)
//   Odd col 3 and row 7 fall off the board and are dropped.
// Destinations with no source (SDR_BORDER) take the FILL value.
// Parameters:
//   FILL   : value driven onto border destinations (default 1)
// Ports:
//   src_i  : input board vector
//   dst_o  : shifted board vector
// -----------------------------------------------------------------------------
module sdr_move_gen_sdr
   import sdr_move_gen_pkg::*;
#(
   parameter logic FILL = 1'b1
) (
   input  logic [ROW_SQ*ROW_CNT-1:0] src_i,
   output logic [ROW_SQ*ROW_CNT-1:0] dst_o
);

   // Each destination selects its unique source; the source row parity is the
   // opposite of the destination row parity.
   for (genvar d = 0; d < ROW_SQ*ROW_CNT; d++) begin : g_dst
      if (SDR_BORDER[d]) begin : g_fill
         assign dst_o[d] = FILL;
      end else if (((d / ROW_SQ) % 2) == 1) begin : g_from_even
         assign dst_o[d] = src_i[d-4];
      end else begin : g_from_odd
         assign dst_o[d] = src_i[d-5];
      end
   end

endmodule : sdr_move_gen_sdr

// File: rtl/sdr_move_gen.sv
// -----------------------------------------------------------------------------
// sdr_move_gen
// Sequential down-right move generator for one side of a checkers board.
// Accepts a board (own/opp) when idle, then performs one diagonal shift per
// cycle through a single shared shifter:
//   SHIFT1 : simple moves and capture candidates from sdr(own)
//   SHIFT2 : capture landings from sdr(captured squares)
//   DONE   : result presented until the consumer accepts it
// Overlapping own/opp squares are treated as own; overlap_err flags them.
//
// Build option:
//   FORCE_JUMP_EN : when defined, move_dst is presented as 0 whenever any
//                   capture exists (mandatory capture); jump_dst unchanged.
//
// Ports:
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   in_valid    : request valid
//   in_ready    : engine idle, request accepted on in_valid
//   own         : squares holding the moving side's pieces
//   opp         : squares holding opponent pieces
//   out_valid   : result valid
//   out_ready   : consumer accepts result
//   move_dst    : empty squares reachable by a one-step down-right move
//   jump_dst    : empty landing squares of a down-right capture
//   jump_any    : OR-reduction of jump_dst
//   overlap_err : own and opp shared a square in this request
// -----------------------------------------------------------------------------
module sdr_move_gen
   import sdr_move_gen_pkg::*;
#(
   parameter int BOARD_W = BOARD_SQ
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BOARD_W-1:0] own,
   input  logic [BOARD_W-1:0] opp,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BOARD_W-1:0] move_dst,
   output logic [BOARD_W-1:0] jump_dst,
   output logic               jump_any,
   output logic               overlap_err
);

   state_e             state_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic [BOARD_W-1:0] own_q;
   logic [BOARD_W-1:0] opp_q;
   logic [BOARD_W-1:0] empty_q;
   logic               ovl_q;
   logic [BOARD_W-1:0] move_q;
   logic [BOARD_W-1:0] cap_q;

   logic [BOARD_W-1:0] move_dst_q;
   logic [BOARD_W-1:0] jump_dst_q;
   logic               jump_any_q;
   logic               overlap_err_q;

   logic [BOARD_W-1:0] shf_src_d;
   logic [BOARD_W-1:0] shf_dst_d;
   logic [BOARD_W-1:0] jump_d;
   logic [BOARD_W-1:0] move_out_d;

   // One shifter serves both passes: own pieces first, captured squares second.
   assign shf_src_d = (state_q == ST_SHIFT2) ? cap_q : own_q;

   sdr_move_gen_sdr #(
      .FILL (1'b0)
   ) u_sdr (
      .src_i (shf_src_d),
      .dst_o (shf_dst_d)
   );

   assign jump_d = shf_dst_d & empty_q;

`ifdef FORCE_JUMP_EN
   assign move_out_d = (|jump_d) ? '0 : move_q;
`else
   assign move_out_d = move_q;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         own_q         <= '0;
         opp_q         <= '0;
         empty_q       <= '0;
         ovl_q         <= 1'b0;
         move_q        <= '0;
         cap_q         <= '0;
         move_dst_q    <= '0;
         jump_dst_q    <= '0;
         jump_any_q    <= 1'b0;
         overlap_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  own_q      <= own;
                  opp_q      <= opp & ~own;
                  empty_q    <= ~(own | opp);
                  ovl_q      <= |(own & opp);
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SHIFT1;
               end
            end
            ST_SHIFT1: begin
               move_q  <= shf_dst_d & empty_q;
               cap_q   <= shf_dst_d & opp_q;
               state_q <= ST_SHIFT2;
            end
            ST_SHIFT2: begin
               // Outputs change only on entry to DONE so they hold through IDLE.
               jump_dst_q    <= jump_d;
               jump_any_q    <= |jump_d;
               move_dst_q    <= move_out_d;
               overlap_err_q <= ovl_q;
               out_valid_q   <= 1'b1;
               state_q       <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign move_dst    = move_dst_q;
   assign jump_dst    = jump_dst_q;
   assign jump_any    = jump_any_q;
   assign overlap_err = overlap_err_q;

endmodule : sdr_move_gen

// File: tb/tb_sdr_move_gen.sv
// -----------------------------------------------------------------------------
// tb_sdr_move_gen
// Self-checking bench for sdr_move_gen and its down-right shifter.
// The reference model walks each own piece square by square (row/col
// arithmetic), and a transaction-level timing model predicts in_ready,
// out_valid and the held outputs every cycle. FORCE_JUMP_EN is honoured.
// -----------------------------------------------------------------------------
module tb_sdr_move_gen;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] own;
   logic [31:0] opp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] move_dst;
   logic [31:0] jump_dst;
   logic        jump_any;
   logic        overlap_err;

   logic [31:0] s1_src, s1_dst, s0_src, s0_dst;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   sdr_move_gen #(.BOARD_W(32)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .own         (own),
      .opp         (opp),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .move_dst    (move_dst),
      .jump_dst    (jump_dst),
      .jump_any    (jump_any),
      .overlap_err (overlap_err)
   );

   sdr_move_gen_sdr #(.FILL(1'b1)) u_sdr_f1 (.src_i(s1_src), .dst_o(s1_dst));
   sdr_move_gen_sdr #(.FILL(1'b0)) u_sdr_f0 (.src_i(s0_src), .dst_o(s0_dst));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Down-right destination of square s, or -1 if it leaves the board.
   function automatic int dr(input int s);
      int r, c;
      r = s / 4;
      c = s % 4;
      if (r == 7) return -1;
      if (r % 2 == 0) return s + 4;
      if (c == 3) return -1;
      return s + 5;
   endfunction

   function automatic logic [31:0] sdr_ref(input logic [31:0] a, input bit fill);
      logic [31:0] o, hit;
      int d;
      o = '0; hit = '0;
      for (int s = 0; s < 32; s++) begin
         d = dr(s);
         if (d >= 0) begin
            hit[d] = 1'b1;
            if (a[s]) o[d] = 1'b1;
         end
      end
      if (fill) o = o | ~hit;
      return o;
   endfunction

   task automatic board_ref(input logic [31:0] po, input logic [31:0] pp,
                            output logic [31:0] mv, output logic [31:0] jp,
                            output logic ov);
      int d, d2;
      mv = '0; jp = '0;
      ov = |(po & pp);
      for (int s = 0; s < 32; s++) begin
         if (po[s]) begin
            d = dr(s);
            if (d >= 0) begin
               if (!po[d] && !pp[d]) mv[d] = 1'b1;
               else if (pp[d] && !po[d]) begin
                  d2 = dr(d);
                  if (d2 >= 0 && !po[d2] && !pp[d2]) jp[d2] = 1'b1;
               end
            end
         end
      end
`ifdef FORCE_JUMP_EN
      if (jp != 0) mv = '0;
`endif
   endtask

   // Transaction timing model: 0 idle, 1/2 shifting, 3 result presented.
   int          m_phase;
   logic [31:0] m_pmove, m_pjump, m_move, m_jump;
   logic        m_povl, m_ovl;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0;
         m_move = '0; m_jump = '0; m_ovl = 1'b0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  board_ref(own, opp, m_pmove, m_pjump, m_povl);
                  m_phase = 1;
               end
            1: m_phase = 2;
            2: begin
                  m_phase = 3;
                  m_move = m_pmove; m_jump = m_pjump; m_ovl = m_povl;
               end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   // Compare process: every cycle, all outputs against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("in_ready",    {31'd0, in_ready},    {31'd0, m_phase == 0});
         check("out_valid",   {31'd0, out_valid},   {31'd0, m_phase == 3});
         check("move_dst",    move_dst,             m_move);
         check("jump_dst",    jump_dst,             m_jump);
         check("jump_any",    {31'd0, jump_any},    {31'd0, m_jump != 0});
         check("overlap_err", {31'd0, overlap_err}, {31'd0, m_ovl});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_sync();
      @(negedge clock);
      #1;
   endtask

   // Issue one request, measure latency, check literal results, then retire it.
   task automatic do_req(input string name, input logic [31:0] po, input logic [31:0] pp,
                         input logic [31:0] e_mv, input logic [31:0] e_jp, input logic e_ov);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin drive_sync(); n++; end
      check({name, "_idle"}, {31'd0, in_ready}, 32'd1);
      own = po; opp = pp; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin @(posedge clock); #1; n++; end
      check({name, "_latency"}, n, 3);
      check({name, "_move"}, move_dst, e_mv);
      check({name, "_jump"}, jump_dst, e_jp);
      check({name, "_any"}, {31'd0, jump_any}, {31'd0, e_jp != 0});
      check({name, "_ovl"}, {31'd0, overlap_err}, {31'd0, e_ov});
      drive_sync();
      out_ready = 1'b1;
      drive_sync();
      out_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] keep_mv, keep_jp;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      own = '0; opp = '0;
      s1_src = '0; s0_src = 32'hFFFF_FFFF;
      #12;
      // Reset state
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_move",      move_dst, 32'd0);
      check("rst_jump",      jump_dst, 32'd0);
      // Shifter standalone and model pins
      check("sdr_fill1_dut", s1_dst, 32'h0101_010F);
      check("sdr_fill0_dut", s0_dst, 32'hFEFE_FEF0);
      check("sdr_fill1_ref", sdr_ref(32'h0, 1'b1), 32'h0101_010F);
      check("sdr_fill0_ref", sdr_ref(32'hFFFF_FFFF, 1'b0), 32'hFEFE_FEF0);
      for (int i = 0; i < 8; i++) begin
         s0_src = $urandom; s1_src = $urandom;
         #1;
         check("sdr_rand_f0", s0_dst, sdr_ref(s0_src, 1'b0));
         check("sdr_rand_f1", s1_dst, sdr_ref(s1_src, 1'b1));
      end
      drive_sync();
      reset_n = 1'b1;
      chk_en = 1'b1;

      // Directed transactions
      do_req("simple", 32'h0000_0200, 32'h0, 32'h0000_2000, 32'h0, 1'b0);
      do_req("jump",   32'h0000_0200, 32'h0000_2000, 32'h0, 32'h0004_0000, 1'b0);
`ifdef FORCE_JUMP_EN
      do_req("mixed",  32'h0000_0201, 32'h0000_2000, 32'h0, 32'h0004_0000, 1'b0);
`else
      do_req("mixed",  32'h0000_0201, 32'h0000_2000, 32'h0000_0010, 32'h0004_0000, 1'b0);
`endif
      do_req("border", 32'h8000_0080, 32'h0, 32'h0, 32'h0, 1'b0);
      do_req("overlap", 32'h0000_0200, 32'h0000_0200, 32'h0000_2000, 32'h0, 1'b1);

      // Stall in DONE with a second request ignored
      do_req("pre_stall", 32'h0000_0200, 32'h0000_2000, 32'h0, 32'h0004_0000, 1'b0);
      drive_sync();
      own = 32'h0000_0001; opp = 32'h0; in_valid = 1'b1;
      @(posedge clock); #1; in_valid = 1'b0;
      while (!out_valid) begin @(posedge clock); #1; end
      keep_mv = move_dst; keep_jp = jump_dst;
      check("stall_move_lit", keep_mv, 32'h0000_0010);
      for (int i = 0; i < 5; i++) begin
         own = 32'h0000_0200; opp = 32'h0000_2000; in_valid = 1'b1;
         drive_sync();
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_move", move_dst, keep_mv);
         check("stall_jump", jump_dst, keep_jp);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drive_sync();
      out_ready = 1'b0;
      check("stall_release_idle", {31'd0, in_ready}, 32'd1);
      check("stall_hold_move", move_dst, 32'h0000_0010);

      // Reset during SHIFT2
      drive_sync();
      own = 32'h0000_0200; opp = 32'h0000_2000; in_valid = 1'b1;
      @(posedge clock); #1; in_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_move",      move_dst, 32'd0);
      check("midrst_jump",      jump_dst, 32'd0);
      drive_sync();
      reset_n = 1'b1;
      drive_sync();

      // Randomized traffic checked every cycle by the compare process
      for (int i = 0; i < 1500; i++) begin
         own = $urandom & $urandom;
         opp = $urandom & $urandom;
         if ($urandom_range(0, 7) != 0) opp = opp & ~own;
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive_sync();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) drive_sync();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sdr_move_gen

// File: doc/sdr_move_gen.md
Name: sdr_move_gen

Overview:
- Computes, for one side, the down-right destination squares on the 32-square checkers board.
  - Simple-move destinations.
  - Capture (jump) landing squares.
- Complements the existing up-left board shifter by moving in the opposite diagonal direction.
- Sequential engine: one diagonal shift per cycle, valid/ready on both input and output.
- Sits between the board-state registers and the move-selection logic.

Parameters:
- BOARD_W, 32, board vector width; fixed at 32, index = 4*row + col, row 0 at top, row-major.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine idle and able to accept.
- own  input  32  squares holding the moving side's pieces.
- opp  input  32  squares holding opponent pieces.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- move_dst  output  32  empty squares reachable by a one-step down-right move.
- jump_dst  output  32  empty landing squares reachable by a down-right capture.
- jump_any  output  1  OR-reduction of jump_dst.
- overlap_err  output  1  own and opp shared at least one square for this request.

Behaviour:
- Reset (async assert, sync-released): FSM=IDLE; in_ready=1; out_valid=0; all result outputs and internal registers 0.
- Down-right map, dest <- src:
  - Even row r, col c -> row r+1, col c.
  - Odd row r, col c<3 -> row r+1, col c+1.
  - Odd col 3 and row 7 leave the board and are dropped.
  - Destinations with no source are 0,1,2,3,8,16,24; they take the FILL value (0 in this block).
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture the following and go to SHIFT1:
    - own_r = own
    - opp_r = opp & ~own
    - empty_r = ~(own|opp)
    - ovl_r = |(own&opp)
  - SHIFT1: s1 = sdr(own_r).
    - Register move_r = s1 & empty_r.
    - Register cap_r = s1 & opp_r.
    - Go to SHIFT2.
  - SHIFT2: register jump_r = sdr(cap_r) & empty_r. Go to DONE.
  - DONE: out_valid=1; outputs driven from registers, stable while out_ready=0. On out_ready, go to IDLE (out_valid=0 next cycle).
- in_ready=0 in SHIFT1/SHIFT2/DONE; in_valid is ignored there (no queuing).
- Latency: acceptance edge to out_valid = 3 cycles. Throughput: one request per 4 cycles with out_ready held high.
- Outputs hold their last values in IDLE until the next DONE.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0, the in-flight request is discarded.
- Overlapping own/opp bits count as own; overlap_err reports the overlap alongside that result.

Optional Feature:
- FORCE_JUMP_EN defined: when jump_any=1 in DONE, move_dst is presented as 0 (mandatory capture rule); jump_dst is unchanged.
- FORCE_JUMP_EN undefined: move_dst is always the raw simple-move set.

Decomposition:
- Shared package:
  - Board width (32), squares per row (4), row count (8).
  - FSM state encoding.
  - Down-right border index list as a 32-bit constant 0x0101010F.
- Sub-module sdr:
  - Purely combinational down-right shifter.
  - Parameter FILL, default 1, for border squares; this block instantiates it with FILL=0.
  - Instanced once, reused for SHIFT1 and SHIFT2 via an input mux.

Test Plan:
- sdr standalone, FILL=1, A=0 -> 0x0101010F; FILL=0, A=0xFFFFFFFF -> 0xFEFEFEF0.
- own=0x00000200 (sq 9), opp=0, pulse in_valid -> out_valid exactly 3 cycles later:
  - move_dst=0x00002000
  - jump_dst=0
  - jump_any=0
- own=0x00000200, opp=0x00002000 ->
  - move_dst=0
  - jump_dst=0x00040000 (sq 18)
  - jump_any=1
- own=0x00000201, opp=0x00002000:
  - Without FORCE_JUMP_EN -> move_dst=0x00000010, jump_dst=0x00040000.
  - With FORCE_JUMP_EN -> move_dst=0, jump_dst=0x00040000.
- Border drop: own=0x80000080 (sq 7 and 31), opp=0 -> move_dst=0, jump_dst=0.
- Handshake/reset:
  - out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid ignored.
  - own=opp=0x00000200 -> overlap_err=1, move_dst=0x00002000.
  - reset_n low during SHIFT2 -> next cycle in_ready=1, out_valid=0, outputs 0.
